// File: rtl/mips_memory_access_sequencer.sv
// MEM-stage data-memory sequencer: lane/alignment decode, valid/ready
// command issue, read-return wait with timeout, and extended load return.
module mips_memory_access_sequencer #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    reqValid,
    output logic                    reqReady,
    input  logic                    reqWrite,
    input  logic [1:0]              reqSize,
    input  logic                    reqDword,
    input  logic                    reqSigned,
    input  logic [ADDR_WIDTH-1:0]   reqAddr,
    input  logic [DATA_WIDTH-1:0]   reqData,
    output logic                    memValid,
    input  logic                    memReady,
    output logic                    memWrite,
    output logic [ADDR_WIDTH-1:0]   memAddr,
    output logic [DATA_WIDTH/8-1:0] memByteEnable,
    output logic [DATA_WIDTH-1:0]   memWriteData,
    input  logic                    memReadValid,
    input  logic [DATA_WIDTH-1:0]   memReadData,
    output logic                    respValid,
    output logic [DATA_WIDTH-1:0]   respData,
    output logic [1:0]              respError,
    output logic                    stall
);
    localparam int LANES = DATA_WIDTH / 8;
    localparam int OFFW  = $clog2(LANES);
    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_e;

    state_e                state_q, state_d;
    logic                  stale_q, stale_d;
    logic [15:0]           timer_q, timer_d;
    logic [1:0]            size_q, size_d;
    logic [OFFW-1:0]       off_q, off_d;
    logic                  signed_q, signed_d;
    logic                  mem_valid_q, mem_valid_d;
    logic                  mem_write_q, mem_write_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [LANES-1:0]      mem_be_q, mem_be_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
    logic [1:0]            resp_error_q, resp_error_d;

    logic [1:0]            size_log;
    logic                  illegal;
    logic                  misaligned;
    logic [2:0]            align_mask;
    logic [8:0]            lane_mask;
    logic [OFFW-1:0]       offset;
    logic [DATA_WIDTH-1:0] rd_shift;
    logic [DATA_WIDTH-1:0] rd_keep;
    logic                  rd_sign;
    logic [DATA_WIDTH-1:0] rd_ext;

    assign offset   = reqAddr[OFFW-1:0];
    assign reqReady = (state_q == ST_IDLE) && !stale_q;
    assign stall    = (state_q != ST_IDLE) || stale_q;

    always_comb begin
        size_log = 2'd0;
        illegal  = 1'b0;
        if (reqDword) begin
            size_log = 2'd3;
            illegal  = (DATA_WIDTH != 64);
        end else begin
            unique case (reqSize)
                2'b01:   size_log = 2'd0;
                2'b10:   size_log = 2'd1;
                2'b11:   size_log = 2'd2;
                default: illegal  = 1'b1;
            endcase
        end
        align_mask = 3'((4'd1 << size_log) - 4'd1);
        lane_mask  = (9'd1 << (4'd1 << size_log)) - 9'd1;
        misaligned = |(reqAddr[2:0] & align_mask);
    end

    // Sign fill is OR-ed above the kept bits so no zero-width replication is needed.
    always_comb begin
        rd_shift = memReadData >> {off_q, 3'b000};
        unique case (size_q)
            2'd0: begin
                rd_keep = DATA_WIDTH'(8'hFF);
                rd_sign = rd_shift[7];
            end
            2'd1: begin
                rd_keep = DATA_WIDTH'(16'hFFFF);
                rd_sign = rd_shift[15];
            end
            2'd2: begin
                rd_keep = DATA_WIDTH'(32'hFFFF_FFFF);
                rd_sign = rd_shift[31];
            end
            default: begin
                rd_keep = '1;
                rd_sign = 1'b0;
            end
        endcase
        rd_ext = (rd_shift & rd_keep)
               | ({DATA_WIDTH{signed_q & rd_sign}} & ~rd_keep);
    end

    always_comb begin
        state_d      = state_q;
        stale_d      = stale_q;
        timer_d      = timer_q;
        size_d       = size_q;
        off_d        = off_q;
        signed_d     = signed_q;
        mem_valid_d  = mem_valid_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;
        resp_valid_d = 1'b0;
        resp_data_d  = '0;
        resp_error_d = 2'b00;

        if (stale_q && memReadValid && state_q != ST_WAIT) stale_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (reqValid && reqReady) begin
                    size_d   = size_log;
                    off_d    = offset;
                    signed_d = reqSigned;
                    if (illegal || misaligned) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_error_d = illegal ? 2'b11 : 2'b01;
                    end else begin
                        state_d     = ST_ISSUE;
                        mem_valid_d = 1'b1;
                        mem_write_d = reqWrite;
                        mem_addr_d  = {reqAddr[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
                        mem_be_d    = lane_mask[LANES-1:0] << offset;
                        mem_wdata_d = reqData << {offset, 3'b000};
                    end
                end
            end
            ST_ISSUE: begin
                if (memReady) begin
                    mem_valid_d = 1'b0;
                    if (mem_write_q) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        timer_d = '0;
                    end
                end
            end
            ST_WAIT: begin
                timer_d = timer_q + 16'd1;
                if (memReadValid) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_data_d  = rd_ext;
                end else if (timer_q == TIMER_LAST) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_error_d = 2'b10;
                    stale_d      = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            stale_q      <= 1'b0;
            timer_q      <= '0;
            size_q       <= '0;
            off_q        <= '0;
            signed_q     <= 1'b0;
            mem_valid_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_be_q     <= '0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_error_q <= 2'b00;
        end else begin
            state_q      <= state_d;
            stale_q      <= stale_d;
            timer_q      <= timer_d;
            size_q       <= size_d;
            off_q        <= off_d;
            signed_q     <= signed_d;
            mem_valid_q  <= mem_valid_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_error_q <= resp_error_d;
        end
    end

    assign memValid      = mem_valid_q;
    assign memWrite      = mem_write_q;
    assign memAddr       = mem_addr_q;
    assign memByteEnable = mem_be_q;
    assign memWriteData  = mem_wdata_q;
    assign respValid     = resp_valid_q;
    assign respData      = resp_data_q;
    assign respError     = resp_error_q;

endmodule

// File: tb/tb_mips_memory_access_sequencer.sv
// Bench for mips_memory_access_sequencer: a 32-bit instance with a short
// timeout and a 64-bit instance for dword and reset-in-flight scenarios.
module tb_mips_memory_access_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  err;
    } exp_t;
    exp_t exp_q[$];
    exp_t e;

    int tests = 0;
    int fails = 0;

    logic        a_reqValid = 0, a_reqReady, a_reqWrite = 0;
    logic [1:0]  a_reqSize = 0;
    logic        a_reqDword = 0, a_reqSigned = 0;
    logic [31:0] a_reqAddr = 0, a_reqData = 0;
    logic        a_memValid, a_memReady = 0, a_memWrite;
    logic [31:0] a_memAddr, a_memWriteData;
    logic [3:0]  a_memByteEnable;
    logic        a_memReadValid = 0;
    logic [31:0] a_memReadData = 0;
    logic        a_respValid, a_stall;
    logic [31:0] a_respData;
    logic [1:0]  a_respError;

    logic        b_reqValid = 0, b_reqReady, b_reqWrite = 0;
    logic [1:0]  b_reqSize = 0;
    logic        b_reqDword = 0, b_reqSigned = 0;
    logic [31:0] b_reqAddr = 0;
    logic [63:0] b_reqData = 0;
    logic        b_memValid, b_memReady = 0, b_memWrite;
    logic [31:0] b_memAddr;
    logic [63:0] b_memWriteData;
    logic [7:0]  b_memByteEnable;
    logic        b_memReadValid = 0;
    logic [63:0] b_memReadData = 0;
    logic        b_respValid, b_stall;
    logic [63:0] b_respData;
    logic [1:0]  b_respError;

    mips_memory_access_sequencer #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)
    ) dut32 (
        .clock(clk), .reset(rst_n),
        .reqValid(a_reqValid), .reqReady(a_reqReady),
        .reqWrite(a_reqWrite), .reqSize(a_reqSize),
        .reqDword(a_reqDword), .reqSigned(a_reqSigned),
        .reqAddr(a_reqAddr), .reqData(a_reqData),
        .memValid(a_memValid), .memReady(a_memReady),
        .memWrite(a_memWrite), .memAddr(a_memAddr),
        .memByteEnable(a_memByteEnable), .memWriteData(a_memWriteData),
        .memReadValid(a_memReadValid), .memReadData(a_memReadData),
        .respValid(a_respValid), .respData(a_respData),
        .respError(a_respError), .stall(a_stall)
    );

    mips_memory_access_sequencer #(
        .DATA_WIDTH(64), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(16)
    ) dut64 (
        .clock(clk), .reset(rst_n),
        .reqValid(b_reqValid), .reqReady(b_reqReady),
        .reqWrite(b_reqWrite), .reqSize(b_reqSize),
        .reqDword(b_reqDword), .reqSigned(b_reqSigned),
        .reqAddr(b_reqAddr), .reqData(b_reqData),
        .memValid(b_memValid), .memReady(b_memReady),
        .memWrite(b_memWrite), .memAddr(b_memAddr),
        .memByteEnable(b_memByteEnable), .memWriteData(b_memWriteData),
        .memReadValid(b_memReadValid), .memReadData(b_memReadData),
        .respValid(b_respValid), .respData(b_respData),
        .respError(b_respError), .stall(b_stall)
    );

    // Stimulus helpers: entered and left at a falling edge.
    task automatic send_a(input logic w, input logic [1:0] sz,
                          input logic dw, input logic sg,
                          input logic [31:0] addr, input logic [31:0] data,
                          output bit ok);
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            if (a_reqReady) begin ok = 1; break; end
            @(negedge clk);
        end
        if (ok) begin
            a_reqValid = 1; a_reqWrite = w; a_reqSize = sz;
            a_reqDword = dw; a_reqSigned = sg;
            a_reqAddr = addr; a_reqData = data;
            @(negedge clk);
            a_reqValid = 0;
        end
    endtask

    task automatic send_b(input logic w, input logic [1:0] sz,
                          input logic dw, input logic sg,
                          input logic [31:0] addr, input logic [63:0] data,
                          output bit ok);
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            if (b_reqReady) begin ok = 1; break; end
            @(negedge clk);
        end
        if (ok) begin
            b_reqValid = 1; b_reqWrite = w; b_reqSize = sz;
            b_reqDword = dw; b_reqSigned = sg;
            b_reqAddr = addr; b_reqData = data;
            @(negedge clk);
            b_reqValid = 0;
        end
    endtask

    task automatic wait_resp_a(output int n);
        n = 0;
        while (!a_respValid && n < 30) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        tests++;
        if (a_memValid !== 0 || a_respValid !== 0 || a_stall !== 0) begin
            fails++;
            $display("FAIL reset_ctrl: got mv=%b rv=%b st=%b want 0 0 0",
                     a_memValid, a_respValid, a_stall);
        end
        tests++;
        if (a_respData !== 0 || a_respError !== 0 || a_memByteEnable !== 0) begin
            fails++;
            $display("FAIL reset_data: got rd=%h re=%b be=%b want 0",
                     a_respData, a_respError, a_memByteEnable);
        end
        rst_n = 1;
        @(negedge clk);
        tests++;
        if (a_reqReady !== 1 || b_reqReady !== 1) begin
            fails++;
            $display("FAIL reset_ready: got a=%b b=%b want 1 1",
                     a_reqReady, b_reqReady);
        end
    endtask

    task automatic test_store_byte;
        bit ok;
        exp_q.push_back('{data: 64'h0, err: 2'b00});
        send_a(1, 2'b01, 0, 0, 32'h1003, 32'h0000_00AB, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL sb_accept: got no reqReady want 1"); end
        tests++;
        if (a_memValid !== 1 || a_memWrite !== 1 || a_memAddr !== 32'h1000) begin
            fails++;
            $display("FAIL sb_cmd: got mv=%b mw=%b addr=%h want 1 1 00001000",
                     a_memValid, a_memWrite, a_memAddr);
        end
        tests++;
        if (a_memByteEnable !== 4'b1000 || a_memWriteData !== 32'hAB00_0000) begin
            fails++;
            $display("FAIL sb_lanes: got be=%b wd=%h want 1000 ab000000",
                     a_memByteEnable, a_memWriteData);
        end
        tests++;
        if (a_stall !== 1 || a_reqReady !== 0) begin
            fails++;
            $display("FAIL sb_stall: got st=%b rr=%b want 1 0", a_stall, a_reqReady);
        end
        a_memReady = 1;
        @(negedge clk);
        a_memReady = 0;
        tests++;
        if (a_respValid !== 1) begin
            fails++;
            $display("FAIL sb_latency: got respValid=%b want 1", a_respValid);
        end else begin
            e = exp_q.pop_front();
            if (a_respData !== e.data[31:0] || a_respError !== e.err) begin
                fails++;
                $display("FAIL sb_resp: got %h/%b want %h/%b",
                         a_respData, a_respError, e.data[31:0], e.err);
            end
        end
        @(negedge clk);
        tests++;
        if (a_respValid !== 0 || a_reqReady !== 1) begin
            fails++;
            $display("FAIL sb_pulse: got rv=%b rr=%b want 0 1", a_respValid, a_reqReady);
        end
    endtask

    task automatic test_load_half(input logic sg, input logic [31:0] want);
        bit ok;
        exp_q.push_back('{data: {32'h0, want}, err: 2'b00});
        send_a(0, 2'b10, 0, sg, 32'h2002, 32'h0, ok);
        tests++;
        if (!ok || a_memValid !== 1 || a_memWrite !== 0 || a_memByteEnable !== 4'b1100) begin
            fails++;
            $display("FAIL lh_cmd: got ok=%b mv=%b mw=%b be=%b want 1 1 0 1100",
                     ok, a_memValid, a_memWrite, a_memByteEnable);
        end
        a_memReady = 1;
        @(negedge clk);
        a_memReady = 0;
        repeat (3) @(negedge clk);
        tests++;
        if (a_respValid !== 0) begin
            fails++;
            $display("FAIL lh_early: got respValid=%b want 0", a_respValid);
        end
        a_memReadValid = 1;
        a_memReadData = 32'h8001_1234;
        @(negedge clk);
        a_memReadValid = 0;
        tests++;
        if (a_respValid !== 1) begin
            fails++;
            $display("FAIL lh_latency: got respValid=%b want 1", a_respValid);
        end else begin
            e = exp_q.pop_front();
            if (a_respData !== e.data[31:0] || a_respError !== e.err) begin
                fails++;
                $display("FAIL lh_resp sg=%b: got %h/%b want %h/%b",
                         sg, a_respData, a_respError, e.data[31:0], e.err);
            end
        end
        @(negedge clk);
        tests++;
        if (a_reqReady !== 1 || a_stall !== 0) begin
            fails++;
            $display("FAIL lh_nostale: got rr=%b st=%b want 1 0", a_reqReady, a_stall);
        end
    endtask

    task automatic test_errors;
        logic [1:0]  sz[3]  = '{2'b11, 2'b11, 2'b00};
        logic        dw[3]  = '{1'b0, 1'b1, 1'b0};
        logic [31:0] ad[3]  = '{32'h3001, 32'h3001, 32'h3000};
        logic [1:0]  er[3]  = '{2'b01, 2'b11, 2'b11};
        bit ok;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('{data: 64'h0, err: er[i]});
            send_a(0, sz[i], dw[i], 0, ad[i], 32'h0, ok);
            tests++;
            if (!ok || a_memValid !== 0 || a_respValid !== 1) begin
                fails++;
                $display("FAIL err%0d_ctrl: got ok=%b mv=%b rv=%b want 1 0 1",
                         i, ok, a_memValid, a_respValid);
            end else begin
                e = exp_q.pop_front();
                if (a_respData !== e.data[31:0] || a_respError !== e.err) begin
                    fails++;
                    $display("FAIL err%0d_resp: got %h/%b want %h/%b",
                             i, a_respData, a_respError, e.data[31:0], e.err);
                end
            end
            @(negedge clk);
        end
        exp_q.delete();
    endtask

    task automatic test_timeout;
        bit ok;
        int n;
        exp_q.push_back('{data: 64'h0, err: 2'b10});
        send_a(0, 2'b11, 0, 0, 32'h0040, 32'h0, ok);
        a_memReady = 1;
        @(negedge clk);
        a_memReady = 0;
        wait_resp_a(n);
        tests++;
        if (!ok || a_respValid !== 1 || n !== 4) begin
            fails++;
            $display("FAIL to_latency: got ok=%b rv=%b waits=%0d want 1 1 4",
                     ok, a_respValid, n);
        end else begin
            e = exp_q.pop_front();
            if (a_respData !== e.data[31:0] || a_respError !== e.err) begin
                fails++;
                $display("FAIL to_resp: got %h/%b want %h/%b",
                         a_respData, a_respError, e.data[31:0], e.err);
            end
        end
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if (a_stall !== 1 || a_reqReady !== 0) begin
                fails++;
                $display("FAIL to_stale%0d: got st=%b rr=%b want 1 0",
                         i, a_stall, a_reqReady);
            end
        end
        a_memReadValid = 1;
        a_memReadData = 32'h0000_DEAD;
        @(negedge clk);
        a_memReadValid = 0;
        tests++;
        if (a_stall !== 0 || a_reqReady !== 1 || a_respValid !== 0) begin
            fails++;
            $display("FAIL to_discard: got st=%b rr=%b rv=%b want 0 1 0",
                     a_stall, a_reqReady, a_respValid);
        end
        exp_q.push_back('{data: 64'h1234_5678, err: 2'b00});
        send_a(0, 2'b11, 0, 0, 32'h0044, 32'h0, ok);
        a_memReady = 1;
        @(negedge clk);
        a_memReady = 0;
        a_memReadValid = 1;
        a_memReadData = 32'h1234_5678;
        @(negedge clk);
        a_memReadValid = 0;
        tests++;
        if (!ok || a_respValid !== 1) begin
            fails++;
            $display("FAIL to_next_valid: got ok=%b rv=%b want 1 1", ok, a_respValid);
        end else begin
            e = exp_q.pop_front();
            if (a_respData !== e.data[31:0] || a_respError !== e.err) begin
                fails++;
                $display("FAIL to_next_resp: got %h/%b want %h/%b",
                         a_respData, a_respError, e.data[31:0], e.err);
            end
        end
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic test_issue_hold;
        bit ok;
        exp_q.push_back('{data: 64'hCAFE_F00D, err: 2'b00});
        send_a(0, 2'b11, 0, 0, 32'h0020, 32'h0, ok);
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (!ok || a_memValid !== 1 || a_memAddr !== 32'h20 ||
                a_memByteEnable !== 4'hF || a_stall !== 1 || a_respValid !== 0) begin
                fails++;
                $display("FAIL hold%0d: got mv=%b addr=%h be=%b st=%b rv=%b want 1 20 1111 1 0",
                         i, a_memValid, a_memAddr, a_memByteEnable, a_stall, a_respValid);
            end
            @(negedge clk);
        end
        a_memReady = 1;
        @(negedge clk);
        a_memReady = 0;
        tests++;
        if (a_respValid !== 0 || a_memValid !== 0) begin
            fails++;
            $display("FAIL hold_wait: got rv=%b mv=%b want 0 0", a_respValid, a_memValid);
        end
        a_memReadValid = 1;
        a_memReadData = 32'hCAFE_F00D;
        @(negedge clk);
        a_memReadValid = 0;
        tests++;
        if (a_respValid !== 1) begin
            fails++;
            $display("FAIL hold_resp_valid: got %b want 1", a_respValid);
        end else begin
            e = exp_q.pop_front();
            if (a_respData !== e.data[31:0] || a_respError !== e.err) begin
                fails++;
                $display("FAIL hold_resp: got %h/%b want %h/%b",
                         a_respData, a_respError, e.data[31:0], e.err);
            end
        end
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic test_dword64;
        bit ok;
        exp_q.push_back('{data: 64'h0123_4567_89AB_CDEF, err: 2'b00});
        send_b(0, 2'b00, 1, 0, 32'h0000_0108, 64'h0, ok);
        tests++;
        if (!ok || b_memValid !== 1 || b_memByteEnable !== 8'hFF || b_memAddr !== 32'h108) begin
            fails++;
            $display("FAIL dw_cmd: got ok=%b mv=%b be=%h addr=%h want 1 1 ff 108",
                     ok, b_memValid, b_memByteEnable, b_memAddr);
        end
        b_memReady = 1;
        @(negedge clk);
        b_memReady = 0;
        @(negedge clk);
        b_memReadValid = 1;
        b_memReadData = 64'h0123_4567_89AB_CDEF;
        @(negedge clk);
        b_memReadValid = 0;
        tests++;
        if (b_respValid !== 1) begin
            fails++;
            $display("FAIL dw_valid: got %b want 1", b_respValid);
        end else begin
            e = exp_q.pop_front();
            if (b_respData !== e.data || b_respError !== e.err) begin
                fails++;
                $display("FAIL dw_resp: got %h/%b want %h/%b",
                         b_respData, b_respError, e.data, e.err);
            end
        end
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        bit ok;
        send_b(0, 2'b11, 0, 1, 32'h0000_010C, 64'h0, ok);
        tests++;
        if (!ok || b_memByteEnable !== 8'hF0 || b_memAddr !== 32'h108) begin
            fails++;
            $display("FAIL rm_cmd: got ok=%b be=%h addr=%h want 1 f0 108",
                     ok, b_memByteEnable, b_memAddr);
        end
        b_memReady = 1;
        @(negedge clk);
        b_memReady = 0;
        @(negedge clk);
        rst_n = 0;
        #1;
        tests++;
        if (b_memValid !== 0 || b_respValid !== 0 || b_stall !== 0 ||
            b_memByteEnable !== 0 || b_memWriteData !== 0 || b_memAddr !== 0 ||
            b_respData !== 0 || b_respError !== 0 || b_memWrite !== 0) begin
            fails++;
            $display("FAIL rm_outputs: got mv=%b rv=%b st=%b be=%h addr=%h rd=%h re=%b want all 0",
                     b_memValid, b_respValid, b_stall, b_memByteEnable,
                     b_memAddr, b_respData, b_respError);
        end
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        b_memReadValid = 1;
        b_memReadData = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        b_memReadValid = 0;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (b_respValid !== 0 || b_reqReady !== 1 || b_stall !== 0) begin
                fails++;
                $display("FAIL rm_ignore%0d: got rv=%b rr=%b st=%b want 0 1 0",
                         i, b_respValid, b_reqReady, b_stall);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_store_byte();
        test_load_half(1'b1, 32'hFFFF_8001);
        test_load_half(1'b0, 32'h0000_8001);
        test_errors();
        test_timeout();
        test_issue_hold();
        test_dword64();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
